// File: rtl/kfps2kb_host_transmitter.sv
// rtl/kfps2kb_host_transmitter.sv - PS/2 host-to-device command byte transmitter
// Optional feature macro: KFPS2KB_HOST_TX_RETRY_EN (one automatic resend after the first NACK).
module kfps2kb_host_transmitter #(
    parameter logic [15:0] inhibit_time = 16'd5000,
    parameter logic [15:0] request_time = 16'hFFFF,
    parameter logic [15:0] over_time    = 16'd1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       device_clock,
    input  logic       device_data,
    output logic       device_clock_out,
    output logic       device_data_out,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       error_flag
);
    typedef enum logic [2:0] {IDLE, INHIBIT, START, REQUEST, SEND, ACK, WAIT_IDLE} state_t;

    state_t      state;
    logic [15:0] timer;
    logic [3:0]  bit_count;
    logic [9:0]  frame;
    logic        prev_device_clock;
    logic        fall;
    logic        timeout;
`ifdef KFPS2KB_HOST_TX_RETRY_EN
    logic        retried;
`endif

    assign fall = prev_device_clock & ~device_clock;

    always_comb begin
        timeout = 1'b0;
        case (state)
            REQUEST:              timeout = (timer == request_time);
            SEND, ACK, WAIT_IDLE: timeout = (timer == over_time);
            default:              timeout = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            timer             <= 16'd0;
            bit_count         <= 4'd0;
            frame             <= 10'd0;
            prev_device_clock <= 1'b0;
            device_clock_out  <= 1'b0;
            device_data_out   <= 1'b0;
            tx_busy           <= 1'b0;
            tx_done           <= 1'b0;
            error_flag        <= 1'b0;
`ifdef KFPS2KB_HOST_TX_RETRY_EN
            retried           <= 1'b0;
`endif
        end else begin
            prev_device_clock <= device_clock;
            tx_done           <= 1'b0;
            error_flag        <= 1'b0;
            if (timeout) begin
                device_clock_out <= 1'b0;
                device_data_out  <= 1'b0;
                tx_busy          <= 1'b0;
                error_flag       <= 1'b1;
                state            <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        device_clock_out <= 1'b0;
                        device_data_out  <= 1'b0;
                        tx_busy          <= 1'b0;
`ifdef KFPS2KB_HOST_TX_RETRY_EN
                        retried          <= 1'b0;
`endif
                        if (tx_write) begin
                            // frame = {stop, odd parity, data}; bits leave LSB first
                            frame            <= {1'b1, ~^tx_data, tx_data};
                            bit_count        <= 4'd0;
                            timer            <= 16'd0;
                            device_clock_out <= 1'b1;
                            tx_busy          <= 1'b1;
                            state            <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (timer == inhibit_time - 16'd1) begin
                            timer           <= 16'd0;
                            device_data_out <= 1'b1;
                            state           <= START;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    START: begin
                        device_clock_out <= 1'b0;
                        timer            <= 16'd0;
                        state            <= REQUEST;
                    end
                    REQUEST, SEND: begin
                        // Each device falling edge presents the next frame bit; the
                        // open-drain line carries the bit, so the pull-down is its inverse.
                        if (fall) begin
                            timer           <= 16'd0;
                            device_data_out <= ~frame[bit_count];
                            if (bit_count == 4'd9) begin
                                state <= ACK;
                            end else begin
                                bit_count <= bit_count + 4'd1;
                                state     <= SEND;
                            end
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    ACK: begin
                        if (fall) begin
                            timer <= 16'd0;
                            if (!device_data) begin
                                state <= WAIT_IDLE;
                            end
`ifdef KFPS2KB_HOST_TX_RETRY_EN
                            else if (!retried) begin
                                retried          <= 1'b1;
                                bit_count        <= 4'd0;
                                device_clock_out <= 1'b1;
                                device_data_out  <= 1'b0;
                                state            <= INHIBIT;
                            end
`endif
                            else begin
                                error_flag <= 1'b1;
                                tx_busy    <= 1'b0;
                                state      <= IDLE;
                            end
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    WAIT_IDLE: begin
                        if (device_clock && device_data) begin
                            tx_done <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end else if (fall) begin
                            timer <= 16'd0;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_kfps2kb_host_transmitter.sv
// tb/tb_kfps2kb_host_transmitter.sv - self-checking bench with a PS/2 device model
module tb_kfps2kb_host_transmitter;
    localparam int INHIBIT_T = 10;
    localparam int REQUEST_T = 100;
    localparam int OVER_T    = 50;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       device_clock, device_data;
    logic       device_clock_out, device_data_out;
    logic [7:0] tx_data = 8'h00;
    logic       tx_write = 1'b0;
    logic       tx_busy, tx_done, error_flag;

    // Open-drain bus: either side pulling low wins over the pull-up.
    assign device_clock = ~(device_clock_out | dev_clk_low);
    assign device_data  = ~(device_data_out | dev_data_low);

    kfps2kb_host_transmitter #(
        .inhibit_time(16'd10), .request_time(16'd100), .over_time(16'd50)
    ) dut (
        .clock(clock), .reset(reset),
        .device_clock(device_clock), .device_data(device_data),
        .device_clock_out(device_clock_out), .device_data_out(device_data_out),
        .tx_data(tx_data), .tx_write(tx_write),
        .tx_busy(tx_busy), .tx_done(tx_done), .error_flag(error_flag)
    );

    always #5 clock = ~clock;

    int total = 0, bad = 0, cyc = 0;
    int done_cnt = 0, err_cnt = 0;
    int inh_run = 0, inh_last = 0, st_run = 0, st_last = 0;
    int req_cyc = 0, last_fall_cyc = 0;
    bit prev_done = 1'b0;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic [9:0] exp_frame;
        int         exp_done;
        int         exp_err;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Advance one cycle and sample everything at the falling edge.
    task automatic tick;
        @(negedge clock);
        cyc++;
        if (prev_done) check("busy_after_done", tx_busy, 0);
        prev_done = tx_done;
        if (tx_done) done_cnt++;
        if (error_flag) err_cnt++;
        if (tx_done || error_flag) check("pulse_exclusive", tx_done & error_flag, 0);
        if (device_clock_out && !device_data_out) inh_run++;
        else begin
            if (inh_run != 0) inh_last = inh_run;
            inh_run = 0;
        end
        if (device_clock_out && device_data_out) st_run++;
        else begin
            if (st_run != 0) st_last = st_run;
            st_run = 0;
        end
    endtask

    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones;
        logic par;
        ones = $countones(d);
        par  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    // Device side of one transfer: waits for the request, then clocks `falls` pulses,
    // sampling the line on each rising edge and optionally ACKing on the 11th.
    task automatic attempt(input int falls, input bit ack, input bit poke,
                           output logic [9:0] got, output int inh, output int st);
        int n;
        got = '0;
        n   = 0;
        while (!(!device_clock_out && device_data_out && tx_busy) && n < 200) begin
            tick;
            n++;
        end
        check("request_seen", n < 200, 1);
        inh     = inh_last;
        st      = st_last;
        req_cyc = cyc;
        if (falls == 0) return;
        if (poke) begin
            tx_data  = 8'h55;
            tx_write = 1'b1;
            tick;
            tx_write = 1'b0;
            tick;
            tick;
        end else begin
            repeat (3) tick;
        end
        for (int k = 1; k <= falls; k++) begin
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (4) tick;
            if (k <= 10) got[k-1] = device_data;
            if (k == 10 && ack) dev_data_low = 1'b1;
            if (k == 11) dev_data_low = 1'b0;
            dev_clk_low = 1'b0;
            repeat (4) tick;
        end
    endtask

    task automatic run_xfer(input vec_t v, input bit poke);
        logic [9:0] got;
        int inh, st;
        done_cnt = 0;
        err_cnt  = 0;
        tx_data  = v.data;
        tx_write = 1'b1;
        tick;
        tx_write = 1'b0;
        tx_data  = 8'($urandom);
        check("busy_after_write", tx_busy, 1);
        attempt(11, v.ack, poke, got, inh, st);
        check("inhibit_len", inh, INHIBIT_T);
        check("start_len", st, 1);
        check("frame_bits", got, v.exp_frame);
`ifdef KFPS2KB_HOST_TX_RETRY_EN
        if (!v.ack) begin
            check("no_err_before_retry", err_cnt, 0);
            attempt(11, 1'b0, 1'b0, got, inh, st);
            check("retry_inhibit_len", inh, INHIBIT_T);
            check("retry_frame_bits", got, v.exp_frame);
        end
`endif
        repeat (20) tick;
        check("done_count", done_cnt, v.exp_done);
        check("err_count", err_cnt, v.exp_err);
        check("idle_busy", tx_busy, 0);
        check("idle_lines", {device_clock_out, device_data_out}, 0);
    endtask

    vec_t vecs[5];

    initial begin
        logic [9:0] got;
        int inh, st, n, d;
        vec_t rv;

        vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1, 0};
        vecs[1] = '{8'hF4, 1'b1, 10'h2F4, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 10'h300, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 10'h3FF, 1, 0};
        vecs[4] = '{8'hA5, 1'b0, 10'h3A5, 0, 1};

        repeat (3) tick;
        check("reset_outputs", {device_clock_out, device_data_out, tx_busy, tx_done, error_flag}, 0);
        reset = 1'b0;
        repeat (3) tick;

        for (int i = 0; i < 5; i++) run_xfer(vecs[i], 1'b0);

        for (int i = 0; i < 6; i++) begin
            rv.data      = 8'($urandom);
            rv.ack       = ($urandom_range(0, 3) != 0);
            rv.exp_frame = model_frame(rv.data);
            rv.exp_done  = rv.ack ? 1 : 0;
            rv.exp_err   = rv.ack ? 0 : 1;
            run_xfer(rv, 1'b0);
        end

        // Device never clocks after the request.
        done_cnt = 0; err_cnt = 0;
        tx_data = 8'h12; tx_write = 1'b1; tick; tx_write = 1'b0;
        attempt(0, 1'b0, 1'b0, got, inh, st);
        n = 0;
        while (!error_flag && n < 300) begin tick; n++; end
        d = cyc - req_cyc;
        check("request_timeout_seen", error_flag, 1);
        check("request_timeout_window", (d >= REQUEST_T && d <= REQUEST_T + 3), 1);
        check("request_timeout_lines", {device_clock_out, device_data_out, tx_busy}, 0);
        repeat (5) tick;
        check("request_timeout_no_done", done_cnt, 0);

        // Device stops after four bits.
        done_cnt = 0; err_cnt = 0;
        tx_data = 8'h34; tx_write = 1'b1; tick; tx_write = 1'b0;
        attempt(4, 1'b0, 1'b0, got, inh, st);
        n = 0;
        while (!error_flag && n < 300) begin tick; n++; end
        d = cyc - last_fall_cyc;
        check("over_timeout_seen", error_flag, 1);
        check("over_timeout_window", (d >= OVER_T && d <= OVER_T + 3), 1);
        check("over_timeout_lines", {device_clock_out, device_data_out}, 0);
        check("over_timeout_bits", got[3:0], 4'h4);
        repeat (5) tick;
        check("over_timeout_counts", {done_cnt[7:0], err_cnt[7:0]}, 16'h0001);

        // Asynchronous reset in the middle of SEND.
        tx_data = 8'h00; tx_write = 1'b1; tick; tx_write = 1'b0;
        attempt(4, 1'b0, 1'b0, got, inh, st);
        check("send_data_driven", device_data_out, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", {device_clock_out, device_data_out, tx_busy}, 0);
        tick;
        reset = 1'b0;
        repeat (3) tick;

        // A write during the transfer must not change the byte on the wire.
        rv.data = 8'h96; rv.ack = 1'b1; rv.exp_frame = model_frame(8'h96);
        rv.exp_done = 1; rv.exp_err = 0;
        run_xfer(rv, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
